// File: rtl/prog_clock_divider.sv
// Runtime-programmable divider: produces a divided clock and a period-start tick.
// New divisor/high-time settings are double-buffered and only take effect on a period boundary.
module prog_clock_divider #(
    parameter int CNT_W        = 28,
    parameter int DEFAULT_DIV  = 2,
    parameter int DEFAULT_HIGH = 1
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             EN,
    input  logic [CNT_W-1:0] DIV_IN,
    input  logic [CNT_W-1:0] HIGH_IN,
    input  logic             LOAD,
    output logic             PENDING,
    output logic             CLK_OUT,
    output logic             TICK,
    output logic [CNT_W-1:0] CUR_DIV
);

    localparam logic [CNT_W-1:0] DEF_DIV  = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] load_div;
    logic             period_end;

    assign load_div   = (DIV_IN == '0) ? CNT_W'(1) : DIV_IN;
    assign period_end = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        high_d    = high_q;
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;
        pend_d    = pend_q;
        run_d     = run_q;
        clk_d     = 1'b0;
        tick_d    = 1'b0;

        if (LOAD) begin
            sh_div_d  = load_div;
            sh_high_d = HIGH_IN;
        end

        // Idle, the first edge after idle, and a period end are all boundaries where settings may change
        if (!EN || !run_q || period_end) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (LOAD) begin
                div_d  = load_div;
                high_d = HIGH_IN;
            end else if (pend_q) begin
                div_d  = sh_div_q;
                high_d = sh_high_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (LOAD) begin
                pend_d = 1'b1;
            end
        end

        run_d = EN;
        if (EN) begin
            clk_d  = (cnt_d < high_d);
            tick_d = (cnt_d == '0);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            cnt_q     <= '0;
            div_q     <= DEF_DIV;
            high_q    <= DEF_HIGH;
            sh_div_q  <= DEF_DIV;
            sh_high_q <= DEF_HIGH;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
            pend_q    <= pend_d;
            run_q     <= run_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign PENDING = pend_q;
    assign CLK_OUT = clk_q;
    assign TICK    = tick_q;
    assign CUR_DIV = div_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed steps plus random traffic, checked against a
// period-queue reference model that expands each new period into its list of output cycles.
module tb_prog_clock_divider;

    localparam int CNT_W = 28;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic [CNT_W-1:0] high_in = '0;
    logic             pending, clk_out, tick;
    logic [CNT_W-1:0] cur_div;

    int passed = 0;
    int total  = 0;
    int stepno = 0;

    prog_clock_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(2), .DEFAULT_HIGH(1)) dut (
        .CLK_IN (clk),
        .RST    (rst),
        .EN     (en),
        .DIV_IN (div_in),
        .HIGH_IN(high_in),
        .LOAD   (load),
        .PENDING(pending),
        .CLK_OUT(clk_out),
        .TICK   (tick),
        .CUR_DIV(cur_div)
    );

    always #5 clk = ~clk;

    // Reference model: active/shadow settings plus the not-yet-emitted cycles of the current period
    int       m_div, m_high, m_sdiv, m_shigh;
    bit       m_pend, m_run;
    bit [1:0] period_q[$];   // {tick, clk_out} per remaining cycle
    bit       e_clk, e_tick;

    function automatic int san(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit l, input int d, input int h);
        bit [1:0] cyc;
        if (r) begin
            m_div = 2; m_high = 1; m_sdiv = 2; m_shigh = 1;
            m_pend = 0; m_run = 0;
            period_q.delete();
            e_clk = 0; e_tick = 0;
            return;
        end
        if (!e || !m_run || period_q.size() == 0) begin
            if (l) begin
                m_div = san(d); m_high = h;
            end else if (m_pend) begin
                m_div = m_sdiv; m_high = m_shigh;
            end
            m_pend = 0;
            period_q.delete();
            if (e) begin
                for (int i = 0; i < m_div; i++)
                    period_q.push_back({(i == 0), (i < m_high)});
            end
        end else if (l) begin
            m_pend = 1;
        end
        if (l) begin
            m_sdiv = san(d); m_shigh = h;
        end
        m_run = e;
        if (e) begin
            cyc = period_q.pop_front();
            e_tick = cyc[1];
            e_clk  = cyc[0];
        end else begin
            e_tick = 0;
            e_clk  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s step %0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int d, input int h);
        rst = r; en = e; load = l;
        div_in  = CNT_W'(d);
        high_in = CNT_W'(h);
        @(posedge clk);
        model_edge(r, e, l, d, h);
        #1;
        stepno++;
        chk("CLK_OUT", 32'(clk_out), 32'(e_clk));
        chk("TICK",    32'(tick),    32'(e_tick));
        chk("PENDING", 32'(pending), 32'(m_pend));
        chk("CUR_DIV", 32'(cur_div), 32'(m_div));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    initial begin
        int guard;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // defaults 2/1
        run(8);
        // idle load 5/2, then run
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 5, 2);
        run(12);
        // mid-period load 3/1 while running 5/2
        step(0, 1, 1, 3, 1);
        run(10);
        // two loads in one period, last wins
        step(0, 1, 1, 4, 2);
        step(0, 1, 1, 6, 3);
        run(14);
        // load exactly on a period-end edge
        guard = 0;
        while (period_q.size() != 0 && guard < 20) begin
            step(0, 1, 0, 0, 0);
            guard++;
        end
        step(0, 1, 1, 7, 2);
        run(9);
        // edge values
        step(0, 0, 1, 0, 1);
        run(5);
        step(0, 0, 1, 3, 0);
        run(7);
        step(0, 0, 1, 4, 9);
        run(6);
        // reset mid-period with a pending load
        step(0, 0, 1, 7, 3);
        run(4);
        step(0, 1, 1, 5, 1);
        step(1, 1, 0, 0, 0);
        run(4);
        // stop mid-high
        step(0, 0, 1, 6, 4);
        run(2);
        step(0, 0, 0, 0, 0);
        run(3);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 11)));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
